// File: rtl/inert_intf_if.sv
`default_nettype none
// ============================================================================
// Module      : inert_intf_if
// Description : Transaction handshake between the inertial-sensor sequencer
//               and the SPI master (start pulse, command word, completion).
// Revision    : 1.0  initial release
// ============================================================================
interface inert_intf_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    // Sequencer side issues transactions; SPI master side completes them.
    modport master (
        output wrt,
        output cmd,
        input  done,
        input  rd_data
    );

    modport slave (
        input  wrt,
        input  cmd,
        output done,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/inert_intf.sv
`default_nettype none
// ============================================================================
// Module      : inert_intf
// Description : Inertial-sensor transaction sequencer. Configures the sensor
//               after power-up, then reads pitch rate and Z acceleration on
//               every data-ready interrupt and presents them with a vld strobe.
// Revision    : 1.0  initial release
// ============================================================================
module inert_intf #(
    parameter int TMR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    inert_intf_if.master       spi,
    output logic signed [15:0] ptch_rt,
    output logic signed [15:0] AZ,
    output logic               vld
);

    localparam logic [15:0] c_CMD_INT_CFG = 16'h0D02;
    localparam logic [15:0] c_CMD_ACC_CFG = 16'h1053;
    localparam logic [15:0] c_CMD_GYR_CFG = 16'h1150;
    localparam logic [15:0] c_CMD_RND_CFG = 16'h1460;
    localparam logic [15:0] c_CMD_RD_PL   = 16'hA200;
    localparam logic [15:0] c_CMD_RD_PH   = 16'hA300;
    localparam logic [15:0] c_CMD_RD_AL   = 16'hAC00;
    localparam logic [15:0] c_CMD_RD_AH   = 16'hAD00;
    localparam logic [TMR_W-1:0] c_TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_PWRUP    = 4'd0,
        S_INIT1    = 4'd1,
        S_INIT2    = 4'd2,
        S_INIT3    = 4'd3,
        S_INIT4    = 4'd4,
        S_WAIT_INT = 4'd5,
        S_RD_PL    = 4'd6,
        S_RD_PH    = 4'd7,
        S_RD_AL    = 4'd8,
        S_RD_AH    = 4'd9
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_int_ff1;
    logic               r_int_ff2;
    logic [7:0]         r_pl;
    logic [7:0]         r_ph;
    logic [7:0]         r_al;
    logic [7:0]         r_ah;
    logic               r_wrt;
    logic [15:0]        r_cmd;
    logic signed [15:0] r_ptch_rt;
    logic signed [15:0] r_az;
    logic               r_vld;

    logic               w_xfer_done;
    logic               w_unused_ok;

    // A done coincident with our own wrt belongs to no transaction of ours.
    assign w_xfer_done = spi.done & ~r_wrt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_PWRUP;
            r_tmr     <= '0;
            r_int_ff1 <= 1'b0;
            r_int_ff2 <= 1'b0;
            r_pl      <= 8'h00;
            r_ph      <= 8'h00;
            r_al      <= 8'h00;
            r_ah      <= 8'h00;
            r_wrt     <= 1'b0;
            r_cmd     <= 16'h0000;
            r_ptch_rt <= 16'sh0000;
            r_az      <= 16'sh0000;
            r_vld     <= 1'b0;
        end else begin
            r_int_ff1 <= INT;
            r_int_ff2 <= r_int_ff1;
            r_wrt     <= 1'b0;
            r_vld     <= 1'b0;

            case (r_state)
                S_PWRUP: begin
                    r_tmr <= r_tmr + c_TMR_ONE;
                    if (&r_tmr) begin
                        r_state <= S_INIT1;
                        r_wrt   <= 1'b1;
                        r_cmd   <= c_CMD_INT_CFG;
                    end
                end

                S_INIT1: if (w_xfer_done) begin
                    r_state <= S_INIT2;
                    r_wrt   <= 1'b1;
                    r_cmd   <= c_CMD_ACC_CFG;
                end

                S_INIT2: if (w_xfer_done) begin
                    r_state <= S_INIT3;
                    r_wrt   <= 1'b1;
                    r_cmd   <= c_CMD_GYR_CFG;
                end

                S_INIT3: if (w_xfer_done) begin
                    r_state <= S_INIT4;
                    r_wrt   <= 1'b1;
                    r_cmd   <= c_CMD_RND_CFG;
                end

                S_INIT4: if (w_xfer_done) begin
                    r_state <= S_WAIT_INT;
                end

                // Interrupt level is sampled only here; nothing is queued.
                S_WAIT_INT: if (r_int_ff2) begin
                    r_state <= S_RD_PL;
                    r_wrt   <= 1'b1;
                    r_cmd   <= c_CMD_RD_PL;
                end

                S_RD_PL: if (w_xfer_done) begin
                    r_pl    <= spi.rd_data[7:0];
                    r_state <= S_RD_PH;
                    r_wrt   <= 1'b1;
                    r_cmd   <= c_CMD_RD_PH;
                end

                S_RD_PH: if (w_xfer_done) begin
                    r_ph    <= spi.rd_data[7:0];
                    r_state <= S_RD_AL;
                    r_wrt   <= 1'b1;
                    r_cmd   <= c_CMD_RD_AL;
                end

                S_RD_AL: if (w_xfer_done) begin
                    r_al    <= spi.rd_data[7:0];
                    r_state <= S_RD_AH;
                    r_wrt   <= 1'b1;
                    r_cmd   <= c_CMD_RD_AH;
                end

                // Both words load on the same edge so the pair stays coherent.
                S_RD_AH: if (w_xfer_done) begin
                    r_ah      <= spi.rd_data[7:0];
                    r_ptch_rt <= {r_ph, r_pl};
                    r_az      <= {spi.rd_data[7:0], r_al};
                    r_vld     <= 1'b1;
                    r_state   <= S_WAIT_INT;
                end

                default: r_state <= S_PWRUP;
            endcase
        end
    end

    assign spi.wrt = r_wrt;
    assign spi.cmd = r_cmd;
    assign ptch_rt = r_ptch_rt;
    assign AZ      = r_az;
    assign vld     = r_vld;

    // Upper receive byte carries nothing; high accel byte bypasses r_ah.
    assign w_unused_ok = &{1'b0, spi.rd_data[15:8], r_ah};

endmodule
`default_nettype wire

// File: doc/inert_intf.md
# inert_intf

Upstream stage of the pitch integrator: a transaction sequencer that brings up the inertial sensor over the existing SPI master, then, on every sensor data-ready interrupt, reads the raw pitch-rate and Z-acceleration registers. It presents them as 16-bit signed words with a single-cycle `vld` strobe. `vld`, `ptch_rt` and `AZ` connect directly to the integrator inputs of the same names. The SPI master itself is not part of this block; this block drives its `wrt`/`cmd` and consumes its `done`/`rd_data`.

## Interface
- `TMR_W`, default 16: width of the power-up wait counter. The bench overrides it with a small value, e.g. 4.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low, applied to every flop.
- `INT`  in  1: sensor data-ready, asynchronous to `clk`, active-high level.
- `done`  in  1: one-cycle pulse from the SPI master when a transaction completes.
- `rd_data`  in  16: SPI master receive word. Only `[7:0]` is meaningful.
- `wrt`  out  1: one-cycle pulse that starts an SPI transaction.
- `cmd`  out  16: transaction word. `[15]` is 1 for read, 0 for write. `[14:8]` is the register address. `[7:0]` is the write data, or don't-care for reads.
- `ptch_rt`  out  16 signed: raw pitch rate as `{high byte, low byte}`.
- `AZ`  out  16 signed: raw Z acceleration as `{high byte, low byte}`.
- `vld`  out  1: one-cycle strobe. `ptch_rt` and `AZ` are new and coherent in this cycle.

## Operation
- **INT synchronization:** `INT` passes through two flops and is used only as `INT_ff2`. Both flops reset to 0.
- **PWRUP:**
  - Entered on reset.
  - A `TMR_W`-bit counter, reset to 0, increments every cycle.
  - When the counter reaches all-ones, go to INIT1.
- **INIT1..INIT4:** four writes, issued in this order:
  - `0x0D02`: INT on data-ready.
  - `0x1053`: accel 208 Hz.
  - `0x1150`: gyro 208 Hz.
  - `0x1460`: rounding on.
- **Issue rule for every transaction:**
  - Entering a transaction state pulses `wrt` for exactly one cycle with `cmd` valid in that cycle.
  - `cmd` is held stable until `done`.
  - On `done`, advance to the next state.
- **WAIT_INT:**
  - Idle, `wrt` low.
  - When `INT_ff2` is 1, go to RD_PL.
- **Read loop:**
  - RD_PL: `cmd` `0xA200`.
  - RD_PH: `cmd` `0xA300`.
  - RD_AL: `cmd` `0xAC00`.
  - RD_AH: `cmd` `0xAD00`.
  - On each `done`, capture `rd_data[7:0]` into the byte holding register for that state: pl, ph, al or ah.
- **Output update:**
  - On `done` in RD_AH, in that same edge, load `ptch_rt <= {ph, pl}` and `AZ <= {rd_data[7:0], al}`, and set `vld` for the next cycle.
  - Then return to WAIT_INT.
- **Output stability:** `ptch_rt` and `AZ` change only at that edge. No partial update is ever visible.
- **Reset values:** all outputs are 0 (`wrt`, `cmd`, `ptch_rt`, `AZ`, `vld`). All holding registers are 0. State is PWRUP.
- **Boundaries:**
  - `INT_ff2` high while in the read loop or init states is ignored. No queued request is kept; it is re-sampled in WAIT_INT.
  - `INT_ff2` still high on return to WAIT_INT starts a new read immediately, which gives back-to-back samples.
  - `done` in PWRUP or WAIT_INT is ignored.
  - `done` in the same cycle as `wrt` is ignored. A transaction completes only on a `done` at least one cycle after its `wrt`.
  - `rst_n` low mid-transaction: immediate return to PWRUP with the counter cleared and `wrt` low. No `vld` is produced for the aborted read.
  - Counter width: all-ones detection must work for any `TMR_W` ≥ 2.

## Timing
- Power-up: first `wrt` occurs `2^TMR_W` cycles after reset release, within ±1.
- `INT` to first read `wrt`: 3 cycles after `INT` rises at a `clk` edge, consisting of 2 sync cycles plus 1 state cycle.
- Between transactions: the next `wrt` occurs exactly 1 cycle after the `done` of the previous transaction.
- Final `done` to `vld`: `vld` is high in the cycle following the final `done`. The outputs are already updated in that cycle.
- `vld` is never high for 2 consecutive cycles.
- Minimum spacing between `vld` pulses is 4 SPI transactions.

## Test plan
- **Bring-up:** `TMR_W`=4, reset release. Expect the first `wrt` at about cycle 16. The SPI model returns `done` 20 cycles after each `wrt`. Expect exactly four `wrt` pulses with `cmd` `0x0D02`, `0x1053`, `0x1150`, `0x1460` in order, then `wrt` stays low while `INT`=0.
- **Single read:** after init, raise `INT` and have the model return bytes `0x34`, `0x12`, `0x78`, `0x56` for the four reads. Expect `cmd` sequence `0xA200`, `0xA300`, `0xAC00`, `0xAD00`, then a one-cycle `vld` with `ptch_rt`=`0x1234` and `AZ`=`0x5678`.
- **Negative values and stability:** bytes `0x00`, `0xFF`, `0x60`, `0xFF` give `ptch_rt`=`0xFF00` (-256) and `AZ`=`0xFF60` (-160). Outputs hold the previous values during all reads and change only with `vld`.
- **INT held high:** `INT` stays high across the whole read. Expect a second read sequence starting 1 cycle after `vld` and no extra `wrt` during the first sequence. A spurious `done` in WAIT_INT is ignored.
- **Reset mid-read:** assert `rst_n`=0 during RD_AL. Expect all outputs 0 immediately, no `vld`, and bring-up replayed from PWRUP after release.
